// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10GBASE-R PHY receive path: sync header
// encodings, block-lock FSM states and header-window constants.
package eth_phy_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam int SH_WINDOW      = 64;
    localparam int SH_INVALID_MAX = 16;

    typedef enum logic [1:0] {
        ST_TEST,
        ST_SLIP,
        ST_WAIT
    } frame_sync_state_t;

endpackage

// File: rtl/eth_phy_10g_rx_frame_sync.sv
// 10GBASE-R receive block-lock state machine.
// Watches the 2-bit sync header of every block, requests bitslips from the
// SERDES gearbox until header alignment is found, and reports block lock.
// Optional feature: define ETH_PHY_10G_RX_FRAME_SYNC_SLIP_CNT_EN to add the
// saturating rx_bitslip_count output.
module eth_phy_10g_rx_frame_sync
    import eth_phy_10g_pkg::*;
#(
    parameter int HDR_WIDTH           = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
    output logic                 serdes_rx_bitslip,
    output logic                 rx_block_lock
`ifdef ETH_PHY_10G_RX_FRAME_SYNC_SLIP_CNT_EN
    ,
    output logic [7:0]           rx_bitslip_count
`endif
);

    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("eth_phy_10g_rx_frame_sync: HDR_WIDTH must be 2");
    end
    if (BITSLIP_HIGH_CYCLES < 1 || BITSLIP_HIGH_CYCLES > 255) begin : g_bad_high
        $error("eth_phy_10g_rx_frame_sync: BITSLIP_HIGH_CYCLES must be 1..255");
    end
    if (BITSLIP_LOW_CYCLES < 0 || BITSLIP_LOW_CYCLES > 255) begin : g_bad_low
        $error("eth_phy_10g_rx_frame_sync: BITSLIP_LOW_CYCLES must be 0..255");
    end

    frame_sync_state_t state_q, state_d;
    logic [5:0] sh_count_q, sh_count_d;
    logic [3:0] sh_invalid_count_q, sh_invalid_count_d;
    logic [7:0] timer_q, timer_d;
    logic       bitslip_q, bitslip_d;
    logic       lock_q, lock_d;
    logic       hdr_valid;

    // A header is usable only when it is exactly one of the two sync codes.
    always_comb begin
        hdr_valid = (serdes_rx_hdr == SYNC_CTRL) || (serdes_rx_hdr == SYNC_DATA);
    end

    // Next-state, counter and registered-output computation.
    // timer counts the remaining cycles of the current SLIP or WAIT phase,
    // loaded with (length-1) so zero marks the last cycle of the phase.
    always_comb begin
        state_d            = state_q;
        sh_count_d         = sh_count_q;
        sh_invalid_count_d = sh_invalid_count_q;
        timer_d            = timer_q;
        bitslip_d          = bitslip_q;
        lock_d             = lock_q;

        case (state_q)
            ST_TEST: begin
                sh_count_d = sh_count_q + 6'd1;
                if (!hdr_valid) begin
                    sh_invalid_count_d = sh_invalid_count_q + 4'd1;
                end
                // Lock loss and unlocked misses both slip; this wins over window end.
                if (!hdr_valid &&
                    (!lock_q || sh_invalid_count_q == 4'(SH_INVALID_MAX - 1))) begin
                    lock_d             = 1'b0;
                    state_d            = ST_SLIP;
                    bitslip_d          = 1'b1;
                    timer_d            = 8'(BITSLIP_HIGH_CYCLES - 1);
                    sh_count_d         = '0;
                    sh_invalid_count_d = '0;
                end else if (sh_count_q == 6'(SH_WINDOW - 1)) begin
                    if (sh_invalid_count_q == '0) begin
                        lock_d = 1'b1;
                    end
                    sh_count_d         = '0;
                    sh_invalid_count_d = '0;
                end
            end

            ST_SLIP: begin
                if (timer_q == '0) begin
                    bitslip_d = 1'b0;
                    if (BITSLIP_LOW_CYCLES == 0) begin
                        state_d = ST_TEST;
                    end else begin
                        state_d = ST_WAIT;
                        timer_d = 8'(BITSLIP_LOW_CYCLES - 1);
                    end
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            ST_WAIT: begin
                if (timer_q == '0) begin
                    state_d = ST_TEST;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            default: begin
                state_d   = ST_TEST;
                bitslip_d = 1'b0;
                lock_d    = 1'b0;
            end
        endcase
    end

    // State, counters and outputs register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_TEST;
            sh_count_q         <= '0;
            sh_invalid_count_q <= '0;
            timer_q            <= '0;
            bitslip_q          <= 1'b0;
            lock_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            sh_count_q         <= sh_count_d;
            sh_invalid_count_q <= sh_invalid_count_d;
            timer_q            <= timer_d;
            bitslip_q          <= bitslip_d;
            lock_q             <= lock_d;
        end
    end

    assign serdes_rx_bitslip = bitslip_q;
    assign rx_block_lock     = lock_q;

`ifdef ETH_PHY_10G_RX_FRAME_SYNC_SLIP_CNT_EN
    // Saturating count of slip requests; SLIP is only entered from TEST.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_bitslip_count <= '0;
        end else if (state_q == ST_TEST && state_d == ST_SLIP &&
                     rx_bitslip_count != 8'hFF) begin
            rx_bitslip_count <= rx_bitslip_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_frame_sync.sv
// Self-checking bench for eth_phy_10g_rx_frame_sync. Two instances share the
// header stream: default slip timing (1 high / 8 low) and 3 high / 0 low.
// Each is compared every cycle against a behavioural model built from the
// block-lock rules using plain counters of remaining slip/ignore cycles.
module tb_eth_phy_10g_rx_frame_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] hdr;
    logic       slip_a, lock_a, slip_b, lock_b;
`ifdef ETH_PHY_10G_RX_FRAME_SYNC_SLIP_CNT_EN
    logic [7:0] cnt_a, cnt_b;
`endif

    always #5 clk = ~clk;

    eth_phy_10g_rx_frame_sync #(
        .HDR_WIDTH(2), .BITSLIP_HIGH_CYCLES(1), .BITSLIP_LOW_CYCLES(8)
    ) dut_a (
        .clk(clk), .rst(rst), .serdes_rx_hdr(hdr),
        .serdes_rx_bitslip(slip_a), .rx_block_lock(lock_a)
`ifdef ETH_PHY_10G_RX_FRAME_SYNC_SLIP_CNT_EN
        , .rx_bitslip_count(cnt_a)
`endif
    );

    eth_phy_10g_rx_frame_sync #(
        .HDR_WIDTH(2), .BITSLIP_HIGH_CYCLES(3), .BITSLIP_LOW_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst), .serdes_rx_hdr(hdr),
        .serdes_rx_bitslip(slip_b), .rx_block_lock(lock_b)
`ifdef ETH_PHY_10G_RX_FRAME_SYNC_SLIP_CNT_EN
        , .rx_bitslip_count(cnt_b)
`endif
    );

    typedef struct {
        int high;
        int low;
        bit locked;
        int seen;        // headers examined in the current window
        int bad;         // invalid headers in the current window
        int slip_left;   // cycles of bitslip still to be driven (incl. current)
        int ignore_left; // cycles of ignored headers still to come
        int slips;
    } model_t;

    model_t ma, mb;
    int tests_run    = 0;
    int tests_failed = 0;

    function automatic model_t model_step(input model_t m, input logic [1:0] h, input logic r);
        model_t n;
        bit     bad_hdr;
        n = m;
        if (r) begin
            n.locked = 0; n.seen = 0; n.bad = 0;
            n.slip_left = 0; n.ignore_left = 0; n.slips = 0;
            return n;
        end
        if (n.slip_left > 0) begin
            n.slip_left--;
            if (n.slip_left == 0) n.ignore_left = n.low;
            return n;
        end
        if (n.ignore_left > 0) begin
            n.ignore_left--;
            return n;
        end
        bad_hdr = !(h == 2'b01 || h == 2'b10);
        n.seen++;
        if (bad_hdr) n.bad++;
        if (bad_hdr && (!n.locked || n.bad == 16)) begin
            n.locked = 0; n.seen = 0; n.bad = 0;
            n.slip_left = n.high;
            if (n.slips < 255) n.slips++;
        end else if (n.seen == 64) begin
            if (n.bad == 0) n.locked = 1;
            n.seen = 0; n.bad = 0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one header, clock it in, advance both models, compare all outputs.
    task automatic tick(input logic [1:0] h, input logic r);
        hdr = h;
        rst = r;
        @(posedge clk);
        ma = model_step(ma, h, r);
        mb = model_step(mb, h, r);
        #1;
        check("a_bitslip", {7'd0, slip_a}, 8'(ma.slip_left > 0));
        check("a_lock",    {7'd0, lock_a}, 8'(ma.locked));
        check("b_bitslip", {7'd0, slip_b}, 8'(mb.slip_left > 0));
        check("b_lock",    {7'd0, lock_b}, 8'(mb.locked));
`ifdef ETH_PHY_10G_RX_FRAME_SYNC_SLIP_CNT_EN
        check("a_slip_count", cnt_a, 8'(ma.slips));
        check("b_slip_count", cnt_b, 8'(mb.slips));
`endif
    endtask

    function automatic logic [1:0] rand_valid();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] rand_invalid();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    initial begin
        bit badpos [64];
        int nbad;
        int p;
        bit done;

        ma = '{high: 1, low: 8, locked: 0, seen: 0, bad: 0, slip_left: 0, ignore_left: 0, slips: 0};
        mb = '{high: 3, low: 0, locked: 0, seen: 0, bad: 0, slip_left: 0, ignore_left: 0, slips: 0};
        hdr = 2'b00;
        rst = 1'b1;

        // Reset state
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b1);
        check("reset_lock", {7'd0, lock_a}, 8'd0);
        check("reset_bitslip", {7'd0, slip_a}, 8'd0);

        // Clean acquisition: lock rises right after the 64th header
        for (int i = 0; i < 63; i++) tick(rand_valid(), 1'b0);
        check("lock_after_63", {7'd0, lock_a}, 8'd0);
        tick(rand_valid(), 1'b0);
        check("lock_after_64", {7'd0, lock_a}, 8'd1);

        // Unlocked miss on header 10: one slip, 9 ignored cycles, then reacquire
        tick(2'b00, 1'b1);
        for (int i = 0; i < 9; i++) tick(rand_valid(), 1'b0);
        tick(rand_invalid(), 1'b0);
        check("slip_on_first_invalid", {7'd0, slip_a}, 8'd1);
        for (int i = 0; i < 9; i++) tick(2'($urandom_range(0, 3)), 1'b0);
        for (int i = 0; i < 63; i++) tick(rand_valid(), 1'b0);
        check("relock_pending", {7'd0, lock_a}, 8'd0);
        tick(rand_valid(), 1'b0);
        check("relock_done", {7'd0, lock_a}, 8'd1);

        // Locked window with 15 scattered invalid headers keeps lock
        foreach (badpos[i]) badpos[i] = 1'b0;
        nbad = 0;
        while (nbad < 15) begin
            p = int'($urandom_range(0, 63));
            if (!badpos[p]) begin badpos[p] = 1'b1; nbad++; end
        end
        for (int i = 0; i < 64; i++) tick(badpos[i] ? rand_invalid() : rand_valid(), 1'b0);
        check("lock_held_15_bad", {7'd0, lock_a}, 8'd1);
        for (int i = 0; i < 64; i++) tick(rand_valid(), 1'b0);
        check("lock_held_clean", {7'd0, lock_a}, 8'd1);

        // Locked window with 16 invalid headers: lock drops right after the 16th
        foreach (badpos[i]) badpos[i] = 1'b0;
        nbad = 0;
        while (nbad < 16) begin
            p = int'($urandom_range(0, 63));
            if (!badpos[p]) begin badpos[p] = 1'b1; nbad++; end
        end
        nbad = 0;
        for (int i = 0; i < 64; i++) begin
            if (badpos[i]) begin
                tick(rand_invalid(), 1'b0);
                nbad++;
                if (nbad == 16) begin
                    check("lock_lost_16_bad", {7'd0, lock_a}, 8'd0);
                    check("slip_on_16_bad", {7'd0, slip_a}, 8'd1);
                    break;
                end
            end else begin
                tick(rand_valid(), 1'b0);
            end
        end

        // Constant 2'b11: periodic slips, then reset in the middle of a pulse
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!done && i >= 150 && ma.slip_left > 0) begin
                tick(2'b11, 1'b1);
                check("rst_mid_slip_bitslip", {7'd0, slip_a}, 8'd0);
                check("rst_mid_slip_lock", {7'd0, lock_a}, 8'd0);
                done = 1'b1;
            end else begin
                tick(2'b11, 1'b0);
            end
        end
        check("rst_mid_slip_reached", {7'd0, done}, 8'd1);

        // Mostly-valid random traffic with occasional bad headers and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 299) == 0)
                tick(2'b00, 1'b1);
            else if ($urandom_range(0, 79) == 0)
                tick(rand_invalid(), 1'b0);
            else
                tick(rand_valid(), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/eth_phy_10g_rx_frame_sync.md
# eth_phy_10g_rx_frame_sync

Block-lock state machine for the 10GBASE-R receive path (IEEE 802.3 clause 49.2.13.2.2). It inspects the 2-bit sync header delivered by the SERDES gearbox each block cycle, drives a bitslip request back to the SERDES until header alignment is found, and asserts block lock. It sits beside the BER monitor on the same `serdes_rx_hdr` stream. Its `rx_block_lock` output gates the descrambler/decoder and the RX status logic.

## Interface
- `HDR_WIDTH`, 2 — sync header width; any other value is an elaboration error.
- `BITSLIP_HIGH_CYCLES`, 1 — cycles `serdes_rx_bitslip` is held high per slip; range 1..255.
- `BITSLIP_LOW_CYCLES`, 8 — cycles after a slip during which headers are ignored; range 0..255.

- `clk`  in  1 — clock, one block per cycle.
- `rst`  in  1 — reset, synchronous, active-high.
- `serdes_rx_hdr`  in  HDR_WIDTH — sync header of the current block.
- `serdes_rx_bitslip`  out  1 — slip request to the SERDES gearbox.
- `rx_block_lock`  out  1 — block lock acquired.
- `rx_bitslip_count`  out  8 — total slips, saturating; present only with the macro in Configuration.

## Operation
- A header is valid when it equals 2'b01 (control) or 2'b10 (data). The values 00 and 11 are invalid.
- `sh_count`: 6-bit count of all headers in the current test window. `sh_invalid_count`: 4-bit count of invalid headers in the window.
- FSM states: `ST_TEST`, `ST_SLIP`, `ST_WAIT`.
- **ST_TEST**: each cycle increments `sh_count`. Invalid headers also increment `sh_invalid_count`.
  - Unlocked, invalid header: go to ST_SLIP. Zero both counters. This applies on any header, including the 64th.
  - Unlocked, 64th header (`sh_count`==63) with no invalid headers in the window, including this one: set `rx_block_lock`=1. Zero both counters.
  - Locked, header that would make `sh_invalid_count` reach 16 (`sh_invalid_count`==15 and invalid): clear `rx_block_lock`. Go to ST_SLIP. Zero both counters. This takes priority over the window-end rule.
  - Locked, 64th header with fewer than 16 invalid headers: zero both counters and stay locked.
- **ST_SLIP**: `serdes_rx_bitslip`=1 for `BITSLIP_HIGH_CYCLES` cycles, then go to ST_WAIT.
- **ST_WAIT**: headers are ignored. Stay for `BITSLIP_LOW_CYCLES` cycles, then go to ST_TEST. If `BITSLIP_LOW_CYCLES`=0, go straight from ST_SLIP to ST_TEST.
- Lock can only be acquired from ST_TEST. `rx_block_lock` is always 0 in ST_SLIP and ST_WAIT.

## Timing
- All outputs are registered. Reset values: `serdes_rx_bitslip`=0, `rx_block_lock`=0, `rx_bitslip_count`=0, state=ST_TEST, all counters 0.
- The header sampled at edge N is reflected in the outputs after edge N.
- Lock latency from first aligned header with clean input: 64 cycles. `rx_block_lock` rises on the cycle after the 64th header is sampled.
- Lock is lost in the cycle after the 16th invalid header within a window. `serdes_rx_bitslip` rises in that same cycle.
- Slip cadence: a slip pulse occurs at most every `BITSLIP_HIGH_CYCLES`+`BITSLIP_LOW_CYCLES`+1 cycles.
- `rst` mid-slip: `serdes_rx_bitslip` drops on the next edge, and `rx_bitslip_count` clears.

## Configuration
- `ETH_PHY_10G_RX_FRAME_SYNC_SLIP_CNT_EN`
  - **Defined**: `rx_bitslip_count` port exists. It increments on each entry to ST_SLIP and saturates at 255.
  - **Undefined**: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `eth_phy_10g_pkg` holds:
  - `SYNC_DATA`=2'b10 and `SYNC_CTRL`=2'b01;
  - the state enum `frame_sync_state_t`;
  - the `SH_WINDOW`=64 and `SH_INVALID_MAX`=16 constants.
- No sub-module. A single FSM plus counters is sufficient.

## Test plan
- Reset, then 64 cycles of hdr=2'b01 → `rx_block_lock` rises on cycle 65; `serdes_rx_bitslip` never asserted.
- Unlocked, hdr=2'b00 on cycle 10 → `serdes_rx_bitslip`=1 for 1 cycle, headers ignored for 8 cycles, then 64 valid headers → lock.
- Locked, 15 invalid headers spread over one 64-header window → stays locked; next window clean → still locked.
- Locked, 16 invalid headers within one window → `rx_block_lock`=0 and `serdes_rx_bitslip`=1 on the cycle after the 16th.
- Constant hdr=2'b11 for 200 cycles with defaults, macro defined → periodic slip pulses, one every 10 cycles; `rx_bitslip_count` increments once per pulse; assert `rst` during a pulse → all outputs 0 on the next cycle.
- `BITSLIP_HIGH_CYCLES`=3, `BITSLIP_LOW_CYCLES`=0, single invalid header → bitslip high for exactly 3 cycles, then ST_TEST resumes immediately.
